// File: rtl/pipelined_adder_pkg.sv
// Shared types and defaults for the pipelined add/subtract unit.
// alu_flags_t is also consumed by the ALU and the branch unit.
package pipelined_adder_pkg;

    localparam int ADDER_WIDTH_DEFAULT  = 32;
    localparam int ADDER_STAGES_DEFAULT = 2;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result bundle of the pipelined adder.
// master drives operands and consumes results; slave is the adder itself.
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
);

    // Handshake: a beat moves on a rising edge exactly when valid && ready are
    // both high; a producer holding valid keeps its payload stable until then.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative
    );

endinterface

// File: rtl/adder_stage.sv
// One pipeline slice: adds chunk IDX of A and effective B plus the incoming
// carry, and registers the partial result, carry and remaining operands.
module adder_stage #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] res_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             sub_o,
    output logic             load_o,
    output logic [WIDTH-1:0] res_nxt_o,
    output logic             carry_nxt_o,
    output logic             msb_cin_nxt_o
);

    localparam int CW = WIDTH / STAGES;
    localparam int LO = IDX * CW;

    logic [CW:0]      sum;
    logic             valid_q, valid_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;

    // An empty slice accepts even when downstream is stalled (bubble collapse).
    assign ready_o = !valid_q || ready_i;
    assign load_o  = valid_i && ready_o;

    always_comb begin
        sum                 = {1'b0, a_i[LO +: CW]} + {1'b0, b_i[LO +: CW]} + {{CW{1'b0}}, carry_i};
        res_nxt_o           = res_i;
        res_nxt_o[LO +: CW] = sum[CW-1:0];
        carry_nxt_o         = sum[CW];
        // Carry into the top bit of this chunk, recovered from the sum bit.
        msb_cin_nxt_o       = a_i[LO+CW-1] ^ b_i[LO+CW-1] ^ sum[CW-1];
    end

    always_comb begin
        valid_d = ready_o ? valid_i : valid_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        if (load_o) begin
            a_d     = a_i;
            b_d     = b_i;
            res_d   = res_nxt_o;
            carry_d = carry_nxt_o;
            sub_d   = sub_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign res_o   = res_q;
    assign carry_o = carry_q;
    assign sub_o   = sub_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with valid/ready flow control and ALU status flags.
// Define PIPELINED_ADDER_FLAGS_EN to build the flag logic; otherwise flags tie to 0.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH_DEFAULT,
    parameter int STAGES = ADDER_STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_adder_if.slave  bus
);

    // Index 0 is the operand port; index k+1 is the output of slice k.
    logic             valid_w [STAGES+1];
    logic             ready_w [STAGES+1];
    logic [WIDTH-1:0] a_w     [STAGES+1];
    logic [WIDTH-1:0] b_w     [STAGES+1];
    logic [WIDTH-1:0] res_w   [STAGES+1];
    logic             carry_w [STAGES+1];
    logic             sub_w   [STAGES+1];

    logic             load_last;
    logic [WIDTH-1:0] res_nxt_last;
    logic             carry_nxt_last;
    logic             msb_cin_last;

    // Subtraction is a + ~b + 1: invert B here and feed sub in as carry-in.
    assign valid_w[0]      = bus.in_valid;
    assign a_w[0]          = bus.a;
    assign b_w[0]          = bus.b ^ {WIDTH{bus.sub}};
    assign res_w[0]        = '0;
    assign carry_w[0]      = bus.sub;
    assign sub_w[0]        = bus.sub;
    assign ready_w[STAGES] = bus.out_ready;
    assign bus.in_ready    = ready_w[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             load;
        logic [WIDTH-1:0] res_nxt;
        logic             carry_nxt;
        logic             msb_cin_nxt;

        adder_stage #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .IDX   (k)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .valid_i      (valid_w[k]),
            .ready_o      (ready_w[k]),
            .ready_i      (ready_w[k+1]),
            .a_i          (a_w[k]),
            .b_i          (b_w[k]),
            .res_i        (res_w[k]),
            .carry_i      (carry_w[k]),
            .sub_i        (sub_w[k]),
            .valid_o      (valid_w[k+1]),
            .a_o          (a_w[k+1]),
            .b_o          (b_w[k+1]),
            .res_o        (res_w[k+1]),
            .carry_o      (carry_w[k+1]),
            .sub_o        (sub_w[k+1]),
            .load_o       (load),
            .res_nxt_o    (res_nxt),
            .carry_nxt_o  (carry_nxt),
            .msb_cin_nxt_o(msb_cin_nxt)
        );

        if (k == STAGES - 1) begin : g_last
            assign load_last      = load;
            assign res_nxt_last   = res_nxt;
            assign carry_nxt_last = carry_nxt;
            assign msb_cin_last   = msb_cin_nxt;
        end else begin : g_mid
            logic unused_nxt;
            assign unused_nxt = ^{load, res_nxt, carry_nxt, msb_cin_nxt};
        end
    end

    assign bus.out_valid = valid_w[STAGES];
    assign bus.result    = res_w[STAGES];

    logic unused_tail;
    assign unused_tail = ^{a_w[STAGES], b_w[STAGES], carry_w[STAGES], sub_w[STAGES]};

`ifdef PIPELINED_ADDER_FLAGS_EN
    alu_flags_t flags_q, flags_d;

    // Flags load with the final slice so they stay aligned with result.
    always_comb begin
        flags_d = flags_q;
        if (load_last) begin
            flags_d.carry    = carry_nxt_last;
            flags_d.overflow = msb_cin_last ^ carry_nxt_last;
            flags_d.zero     = ~|res_nxt_last;
            flags_d.negative = res_nxt_last[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.carry    = flags_q.carry;
    assign bus.overflow = flags_q.overflow;
    assign bus.zero     = flags_q.zero;
    assign bus.negative = flags_q.negative;
`else
    logic unused_flags;
    assign unused_flags = ^{load_last, res_nxt_last, carry_nxt_last, msb_cin_last};

    assign bus.carry    = 1'b0;
    assign bus.overflow = 1'b0;
    assign bus.zero     = 1'b0;
    assign bus.negative = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at STAGES = 1, 2 and 4 driven from shared stimulus;
// the STAGES=2 instance also has a queue scoreboard and stall-stability monitor.
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    localparam int W  = 32;
    localparam int BW = W + 4;
`ifdef PIPELINED_ADDER_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic [3:0]   flags;
    } vec_t;

    // ---------------- clock / reset / drive signals ----------------
    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         sub       = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int delivered = 0;

    logic [BW-1:0] exp_q[$];

    // ---------------- DUTs ----------------
    pipelined_adder_if #(.WIDTH(W)) bus1 ();
    pipelined_adder_if #(.WIDTH(W)) bus2 ();
    pipelined_adder_if #(.WIDTH(W)) bus4 ();

    assign bus1.in_valid = in_valid;
    assign bus1.a = a;
    assign bus1.b = b;
    assign bus1.sub = sub;
    assign bus1.out_ready = out_ready;
    assign bus2.in_valid = in_valid;
    assign bus2.a = a;
    assign bus2.b = b;
    assign bus2.sub = sub;
    assign bus2.out_ready = out_ready;
    assign bus4.in_valid = in_valid;
    assign bus4.a = a;
    assign bus4.b = b;
    assign bus4.sub = sub;
    assign bus4.out_ready = out_ready;

    pipelined_adder #(.WIDTH(W), .STAGES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipelined_adder #(.WIDTH(W), .STAGES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    pipelined_adder #(.WIDTH(W), .STAGES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic          ov [3];
    logic          ir [3];
    logic [BW-1:0] bt [3];

    assign ov[0] = bus1.out_valid;
    assign ov[1] = bus2.out_valid;
    assign ov[2] = bus4.out_valid;
    assign ir[0] = bus1.in_ready;
    assign ir[1] = bus2.in_ready;
    assign ir[2] = bus4.in_ready;
    assign bt[0] = {bus1.result, bus1.carry, bus1.overflow, bus1.zero, bus1.negative};
    assign bt[1] = {bus2.result, bus2.carry, bus2.overflow, bus2.zero, bus2.negative};
    assign bt[2] = {bus4.result, bus4.carry, bus4.overflow, bus4.zero, bus4.negative};

    // ---------------- helpers ----------------
    function automatic int stg(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    function automatic logic [BW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
        logic [W-1:0] ye;
        logic [W:0]   full;
        alu_flags_t   f;
        ye         = s ? ~y : y;
        full       = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, s};
        f.carry    = full[W];
        f.overflow = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
        f.zero     = (full[W-1:0] == '0);
        f.negative = full[W-1];
        if (!FLAGS_ON) f = '0;
        return {full[W-1:0], f};
    endfunction

    function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                input logic [W-1:0] r, input logic [3:0] f);
        vec_t v;
        v.a = x;
        v.b = y;
        v.sub = s;
        v.res = r;
        v.flags = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
    endtask

    // ---------------- scoreboard / monitor for the STAGES=2 instance ----------------
    logic          stall_hold = 1'b0;
    logic [BW-1:0] held_beat  = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_hold = 1'b0;
        end else begin
            if (stall_hold) begin
                check("stall_valid_held", ov[1], 1'b1);
                check("stall_beat_held", bt[1], held_beat);
            end
            if (ov[1] && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected no beat", bt[1]);
                end else begin
                    check("sb_beat", bt[1], exp_q.pop_front());
                    delivered++;
                end
            end
            stall_hold = ov[1] && !out_ready;
            held_beat  = bt[1];
            if (in_valid && ir[1]) exp_q.push_back(model(a, b, sub));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    vec_t          tbl [12];
    logic [BW-1:0] exp_beat;
    logic [W-1:0]  sa [6];
    logic [W-1:0]  sb [6];
    logic          ss [6];

    initial begin
        tbl[0]  = mk(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000);
        tbl[1]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 4'b1001);
        tbl[2]  = mk(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000);
        tbl[3]  = mk(32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b1010);
        tbl[4]  = mk(32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 4'b0001);
        tbl[5]  = mk(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100);
        tbl[6]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101);
        tbl[7]  = mk(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0010);
        tbl[8]  = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1110);
        tbl[9]  = mk(32'h1234_5678, 32'h1234_5679, 1'b1, 32'hFFFF_FFFF, 4'b0001);
        tbl[10] = mk(32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FF, 4'b1000);
        tbl[11] = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010);
        for (int i = 0; i < 6; i++) begin
            sa[i] = $urandom;
            sb[i] = $urandom;
            ss[i] = 1'($urandom_range(0, 1));
        end

        // Reset state: after the first edge with rst high.
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_out_valid_s%0d", stg(d)), ov[d], 1'b0);
            check($sformatf("rst_beat_s%0d", stg(d)), bt[d], '0);
            check($sformatf("rst_in_ready_s%0d", stg(d)), ir[d], 1'b1);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Table vectors: one beat at a time, value and latency on all three depths.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 drive(tbl[i].a, tbl[i].b, tbl[i].sub);
            @(posedge clk);
            #1 in_valid = 1'b0;
            exp_beat = {tbl[i].res, (FLAGS_ON ? tbl[i].flags : 4'b0000)};
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                for (int d = 0; d < 3; d++) begin
                    check($sformatf("lat_s%0d_v%0d_c%0d", stg(d), i, c), ov[d], (c == stg(d)));
                    if (c == stg(d))
                        check($sformatf("beat_s%0d_v%0d", stg(d), i), bt[d], exp_beat);
                end
            end
        end

        // Stream of 6 beats with out_ready low for three cycles mid-stream.
        begin
            int   sent;
            int   cyc;
            int   del0;
            logic acc;
            sent = 0;
            cyc  = 0;
            del0 = delivered;
            @(posedge clk);
            #1;
            while (sent < 6 && cyc < 40) begin
                out_ready = !(cyc >= 2 && cyc <= 4);
                drive(sa[sent], sb[sent], ss[sent]);
                @(negedge clk);
                if (cyc >= 2 && cyc <= 4)
                    check($sformatf("stall_in_ready_c%0d", cyc), ir[1], 1'b0);
                if (cyc == 5)
                    check("resume_in_ready", ir[1], 1'b1);
                acc = ir[1];
                @(posedge clk);
                #1;
                if (acc) sent++;
                cyc++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("stream_all_sent", BW'(sent), BW'(6));
            for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
            check("stream_drained", BW'(exp_q.size()), '0);
            check("stream_delivered", BW'(delivered - del0), BW'(6));
        end

        // Reset with two beats in flight; a beat offered during reset is dropped.
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(32'h0000_0011, 32'h0000_0022, 1'b0);
        @(posedge clk);
        #1 drive(32'h0000_0033, 32'h0000_0044, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        drive(32'h0000_0009, 32'h0000_0009, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", ov[1], 1'b0);
        check("post_rst_beat", bt[1], '0);
        check("post_rst_queue_empty", BW'(exp_q.size()), '0);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check($sformatf("post_rst_quiet_%0d", t), ov[1], 1'b0);
        end

        // 1 + 1 after reset, normal latency.
        @(posedge clk);
        #1 drive(32'h0000_0001, 32'h0000_0001, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("after_rst_lat_c1", ov[1], 1'b0);
        @(negedge clk);
        check("after_rst_lat_c2", ov[1], 1'b1);
        check("after_rst_beat", bt[1], {32'h0000_0002, 4'b0000});
        repeat (3) @(negedge clk);
        check("final_queue_empty", BW'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
